// File: rtl/imem_uart_loader.sv
// UART program loader: receives an 8N1 byte stream (16-bit LE word count, then LE words)
// and writes each assembled word into instruction memory port A with a one-cycle strobe.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 100,
    parameter int ADDR_W       = 14,
    parameter int BYTE_TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              uart_rx,
    output logic              load_active,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [31:0]       dina,
    output logic [ADDR_W:0]   words_loaded,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam int TO_W = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(BYTE_TIMEOUT);
    localparam logic [31:0] N_MAX = 32'd1 << ADDR_W;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state, rx_state_nxt;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_byte;
    logic             rx_tick;
    logic             byte_valid;
    logic             framing_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_tick      = (rx_cnt == ((rx_state == RX_START) ? HALF_M1 : FULL_M1));
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_state_nxt = RX_START;
            RX_START: if (rx_tick) rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
            RX_STOP:  if (rx_tick) rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_byte     <= '0;
            byte_valid  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            framing_err <= 1'b0;
            if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
            else                                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_START) rx_bit <= '0;
            if (rx_state == RX_DATA && rx_tick) begin
                rx_byte <= {rx_sync, rx_byte[7:1]};
                rx_bit  <= rx_bit + 1'b1;
            end
            if (rx_state == RX_STOP && rx_tick) begin
                byte_valid  <= rx_sync;
                framing_err <= !rx_sync;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load protocol FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t          state, state_nxt;
    logic [15:0]     n_words;
    logic [15:0]     hdr_n;
    logic [23:0]     word_buf;
    logic [1:0]      byte_idx;
    logic [TO_W-1:0] to_cnt;
    logic            timeout;
    logic            receiving;
    logic            start_session;
    logic [ADDR_W:0] wl_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        hdr_n         = {rx_byte, n_words[7:0]};
        timeout       = (to_cnt == TO_MAX);
        wl_inc        = words_loaded + 1'b1;
        receiving     = (state == S_HDR_LO) || (state == S_HDR_HI) || (state == S_DATA);
        start_session = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nxt = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (framing_err || timeout) state_nxt = S_ERR;
                else if (byte_valid)        state_nxt = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (framing_err || timeout) state_nxt = S_ERR;
                else if (byte_valid) begin
                    if (hdr_n == 16'd0)            state_nxt = S_DONE;
                    else if (32'(hdr_n) > N_MAX)   state_nxt = S_ERR;
                    else                           state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (framing_err || timeout)              state_nxt = S_ERR;
                else if (byte_valid && byte_idx == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                state_nxt = (32'(wl_inc) == 32'(n_words)) ? S_DONE : S_DATA;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_words      <= '0;
            word_buf     <= '0;
            byte_idx     <= '0;
            to_cnt       <= '0;
            words_loaded <= '0;
            addra        <= '0;
            dina         <= '0;
        end else if (start_session) begin
            words_loaded <= '0;
            byte_idx     <= '0;
            to_cnt       <= '0;
        end else begin
            if (byte_valid)                      to_cnt <= '0;
            else if (receiving && !timeout)      to_cnt <= to_cnt + 1'b1;
            if (state == S_HDR_LO && byte_valid) n_words[7:0]  <= rx_byte;
            if (state == S_HDR_HI && byte_valid) n_words[15:8] <= rx_byte;
            if (state == S_DATA && byte_valid) begin
                word_buf <= {rx_byte, word_buf[23:8]};
                byte_idx <= byte_idx + 1'b1;
            end
            // Address/data latch only when WRITE is actually entered, so they hold otherwise.
            if (state == S_DATA && state_nxt == S_WRITE) begin
                addra <= words_loaded[ADDR_W-1:0];
                dina  <= {rx_byte, word_buf};
            end
            if (state == S_WRITE) words_loaded <= wl_inc;
        end
    end

    assign wea         = (state == S_WRITE);
    assign done        = (state == S_DONE);
    assign err         = (state == S_ERR);
    assign load_active = (state == S_HDR_LO) || (state == S_HDR_HI) ||
                         (state == S_DATA)   || (state == S_WRITE);

endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboard bench for imem_uart_loader: expected writes are queued by the stimulus,
// a negedge monitor pops and compares them on every wea pulse.
module tb_imem_uart_loader;

    localparam int CPB    = 16;
    localparam int ADDR_W = 14;
    localparam int TMO    = 2000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              uart_rx;
    logic              load_active;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [31:0]       dina;
    logic [ADDR_W:0]   words_loaded;
    logic              done;
    logic              err;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    imem_uart_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W(ADDR_W),
        .BYTE_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .uart_rx(uart_rx),
        .load_active(load_active),
        .wea(wea),
        .addra(addra),
        .dina(dina),
        .words_loaded(words_loaded),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wea === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0h data=%h, required no write", addra, dina);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 64'(addra), 64'(e.addr));
                check("write_data", 64'(dina), 64'(e.data));
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [7:0] v;
        v = b;
        uart_rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = v[i];
            wait_clks(CPB);
        end
        uart_rx = stop_bit;
        wait_clks(CPB);
        uart_rx = 1'b1;
        wait_clks(4);
    endtask

    task automatic pulse_start;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_end(input string name, input int lim);
        int k;
        k = 0;
        while (!(done === 1'b1 || err === 1'b1) && k < lim) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(done | err), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wea"}, 64'(wea), 64'd0);
        check({tag, "_addra"}, 64'(addra), 64'd0);
        check({tag, "_dina"}, 64'(dina), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_active"}, 64'(load_active), 64'd0);
    endtask

    task automatic check_queue_empty(input string name);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        uart_rx = 1'b1;
        wait_clks(5);
        check_all_zero("reset");
        rst_n = 1'b1;
        wait_clks(5);

        // Short low glitch while idle must be rejected.
        uart_rx = 1'b0;
        wait_clks(3);
        uart_rx = 1'b1;
        wait_clks(40);
        check_all_zero("glitch_idle");

        // Two-word program.
        expect_write(14'd0, 32'h0010_0513);
        expect_write(14'd1, 32'h0000_0073);
        pulse_start();
        check("a_active", 64'(load_active), 64'd1);
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1);
        send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h73, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        wait_end("a_end_bound", 200);
        check("a_done", 64'(done), 64'd1);
        check("a_err", 64'(err), 64'd0);
        check("a_words", 64'(words_loaded), 64'd2);
        check("a_active_end", 64'(load_active), 64'd0);
        check_queue_empty("a_queue");

        // Zero-length header finishes immediately after the second byte.
        pulse_start();
        check("z_done_cleared", 64'(done), 64'd0);
        check("z_words_cleared", 64'(words_loaded), 64'd0);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        check("z_done", 64'(done), 64'd1);
        check("z_words", 64'(words_loaded), 64'd0);
        check("z_active", 64'(load_active), 64'd0);

        // Idle line mid-word times out.
        pulse_start();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        wait_clks(1800);
        check("t_err_early", 64'(err), 64'd0);
        check("t_active_early", 64'(load_active), 64'd1);
        wait_end("t_end_bound", 400);
        check("t_err", 64'(err), 64'd1);
        check("t_done", 64'(done), 64'd0);
        check("t_active", 64'(load_active), 64'd0);

        // Framing error aborts; a fresh session (with a header-time glitch) recovers.
        pulse_start();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hA5, 1'b0);
        check("f_err", 64'(err), 64'd1);
        check("f_active", 64'(load_active), 64'd0);
        expect_write(14'd0, 32'hDEAD_BEEF);
        expect_write(14'd1, 32'h1234_5678);
        pulse_start();
        check("f_err_cleared", 64'(err), 64'd0);
        uart_rx = 1'b0;
        wait_clks(3);
        uart_rx = 1'b1;
        wait_clks(40);
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
        send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        wait_end("r_end_bound", 200);
        check("r_done", 64'(done), 64'd1);
        check("r_err", 64'(err), 64'd0);
        check("r_words", 64'(words_loaded), 64'd2);
        check_queue_empty("r_queue");

        // Asynchronous reset with three bytes of a word buffered.
        pulse_start();
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1); send_byte(8'hCC, 1'b1);
        check("m_active", 64'(load_active), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(3);
        send_byte(8'hDD, 1'b1);
        check_all_zero("post_reset_byte");

        expect_write(14'd0, 32'hCAFE_F00D);
        expect_write(14'd1, 32'h0403_0201);
        pulse_start();
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h0D, 1'b1); send_byte(8'hF0, 1'b1);
        send_byte(8'hFE, 1'b1); send_byte(8'hCA, 1'b1);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        wait_end("p_end_bound", 200);
        check("p_done", 64'(done), 64'd1);
        check("p_words", 64'(words_loaded), 64'd2);
        check("p_active", 64'(load_active), 64'd0);
        wait_clks(10);
        check_queue_empty("p_queue");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
